// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter: mode encodings, the reserved-mode
// test and the default-sized beat record that travels down the pipe.
package shift_pkg;

   localparam int STAGE_WIDTH = 32;
   localparam int STAGE_TAG_W = 4;
   localparam int STAGE_SHW   = $clog2(STAGE_WIDTH);

   typedef enum logic [2:0] {
      SHIFT_SLL = 3'b000,
      SHIFT_SRL = 3'b001,
      SHIFT_SRA = 3'b010,
      SHIFT_ROL = 3'b011,
      SHIFT_ROR = 3'b100
   } shift_mode_e;

   typedef struct packed {
      logic [STAGE_WIDTH-1:0] data;
      logic [STAGE_SHW-1:0]   amt;
      logic [2:0]             mode;
      logic [STAGE_TAG_W-1:0] tag;
      logic                   err;
   } stage_t;

   function automatic logic is_reserved_mode(input logic [2:0] mode);
      return (mode > 3'b100);
   endfunction

endpackage

// File: rtl/shift_level.sv
// One level of the barrel shifter: shift or rotate by 2^K when en_i is set,
// otherwise pass the operand through. Reserved modes always pass through.
module shift_level
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K     = 0
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [2:0]       mode_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int S = 1 << K;

   always_comb begin
      data_o = data_i;
      if (en_i) begin
         case (mode_i)
            SHIFT_SLL: data_o = data_i << S;
            SHIFT_SRL: data_o = data_i >> S;
            SHIFT_SRA: data_o = $unsigned($signed(data_i) >>> S);
            SHIFT_ROL: data_o = {data_i[WIDTH-S-1:0], data_i[WIDTH-1:WIDTH-S]};
            SHIFT_ROR: data_o = {data_i[S-1:0], data_i[WIDTH-1:S]};
            default:   data_o = data_i;
         endcase
      end else begin
         data_o = data_i;
      end
   end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides. Either one register per
// shift level (PIPELINED=1) or a combinational shifter into a single output register.
module barrel_shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SHW       = $clog2(WIDTH),
   parameter int PIPELINED = 1,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [2:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam int NSTG = (PIPELINED != 0) ? SHW : 1;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   amt;
      logic [2:0]       mode;
      logic [TAG_W-1:0] tag;
      logic             err;
   } beat_t;

   beat_t            in_beat_s;
   beat_t            stage_q    [NSTG];
   beat_t            stage_d    [NSTG];
   logic [NSTG-1:0]  valid_q;
   logic [NSTG-1:0]  up_valid_s;
   logic [NSTG:0]    ready_s;
   beat_t            lvl_src_s  [SHW];
   logic [WIDTH-1:0] lvl_res_s  [SHW];

   assign in_beat_s = '{data: in_data, amt: in_amt, mode: in_mode,
                        tag: in_tag, err: is_reserved_mode(in_mode)};

   // Level k is fed by the input beat, by stage k-1, or by level k-1 directly.
   for (genvar k = 0; k < SHW; k++) begin : g_lvl
      beat_t            src_s;
      logic [WIDTH-1:0] res_s;

      if (k == 0) begin : g_head
         assign src_s = in_beat_s;
      end else if (PIPELINED != 0) begin : g_reg
         assign src_s = stage_q[k-1];
      end else begin : g_comb
         always_comb begin
            src_s      = in_beat_s;
            src_s.data = g_lvl[k-1].res_s;
         end
      end

      shift_level #(.WIDTH(WIDTH), .K(k)) u_level (
         .data_i (src_s.data),
         .mode_i (src_s.mode),
         .en_i   (src_s.amt[k]),
         .data_o (res_s)
      );

      assign lvl_src_s[k] = src_s;
      assign lvl_res_s[k] = res_s;
   end

   always_comb begin
      up_valid_s[0] = in_valid;
      for (int k = 1; k < NSTG; k++) begin
         up_valid_s[k] = valid_q[k-1];
      end
   end

   // A stage may load when empty or when its successor drains this cycle.
   always_comb begin
      ready_s[NSTG] = out_ready;
      for (int k = NSTG - 1; k >= 0; k--) begin
         ready_s[k] = !valid_q[k] || ready_s[k+1];
      end
   end

   always_comb begin
      for (int k = 0; k < NSTG; k++) begin
         stage_d[k]      = (PIPELINED != 0) ? lvl_src_s[k] : in_beat_s;
         stage_d[k].data = (PIPELINED != 0) ? lvl_res_s[k] : lvl_res_s[SHW-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < NSTG; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NSTG; k++) begin
            if (ready_s[k]) begin
               valid_q[k] <= up_valid_s[k];
               if (up_valid_s[k]) begin
                  stage_q[k] <= stage_d[k];
               end
            end
         end
      end
   end

   assign in_ready  = ready_s[0];
   assign out_valid = valid_q[NSTG-1];
   assign out_data  = stage_q[NSTG-1].data;
   assign out_tag   = stage_q[NSTG-1].tag;
   assign out_err   = stage_q[NSTG-1].err;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe: a 32-bit pipelined instance and an 8-bit
// single-register instance, checked against an arithmetic reference model.
module tb_barrel_shift_pipe;

   typedef struct packed {
      logic [63:0] data;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   logic        clk, rst;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
   logic [31:0] a_in_data, a_out_data;
   logic [4:0]  a_in_amt;
   logic [2:0]  a_in_mode;
   logic [3:0]  a_in_tag, a_out_tag;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
   logic [7:0]  b_in_data, b_out_data;
   logic [2:0]  b_in_amt;
   logic [2:0]  b_in_mode;
   logic [3:0]  b_in_tag, b_out_tag;

   int   checks = 0;
   int   errors = 0;
   int   rdy_mode;
   exp_t a_q[$];
   exp_t b_q[$];
   logic [31:0] a_last_data, a_hold_data;
   logic [7:0]  b_last_data, b_hold_data;
   logic [3:0]  a_last_tag, b_last_tag, a_hold_tag, b_hold_tag;
   logic        a_last_err, b_last_err, a_hold_err, b_hold_err;
   bit          a_stall = 0, b_stall = 0;

   barrel_shift_pipe #(.WIDTH(32), .PIPELINED(1), .TAG_W(4)) u_dut32 (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_amt(a_in_amt), .in_mode(a_in_mode), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_tag(a_out_tag), .out_err(a_out_err)
   );

   barrel_shift_pipe #(.WIDTH(8), .PIPELINED(0), .TAG_W(4)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_amt(b_in_amt), .in_mode(b_in_mode), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_tag(b_out_tag), .out_err(b_out_err)
   );

   always #5 clk = ~clk;

   // Reference: whole-amount shift/rotate on a w-bit value held in 64 bits.
   function automatic exp_t model(input int w, input logic [63:0] d, input int amt,
                                  input logic [2:0] m, input logic [3:0] t);
      logic [63:0] mask = (64'd1 << w) - 64'd1;
      exp_t r;
      r.tag = t;
      r.err = 1'b0;
      case (m)
         3'd0:    r.data = (d << amt) & mask;
         3'd1:    r.data = d >> amt;
         3'd2:    r.data = (d >> amt) | (d[w-1] ? (mask & ~(mask >> amt)) : 64'd0);
         3'd3:    r.data = ((d << amt) | (d >> (w - amt))) & mask;
         3'd4:    r.data = ((d >> amt) | (d << (w - amt))) & mask;
         default: begin r.data = d; r.err = 1'b1; end
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       begin a_out_ready = 1'b0; b_out_ready = 1'b0; end
         1:       begin a_out_ready = 1'b1; b_out_ready = 1'b1; end
         default: begin
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
         end
      endcase
   end

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst) begin
         if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_beat actual=%0h required=none", a_out_data);
            end else begin
               e = a_q.pop_front();
               chk("a_data", a_out_data, e.data);
               chk("a_tag", a_out_tag, e.tag);
               chk("a_err", a_out_err, e.err);
               a_last_data = a_out_data; a_last_tag = a_out_tag; a_last_err = a_out_err;
            end
         end
         if (a_in_valid && a_in_ready)
            a_q.push_back(model(32, a_in_data, a_in_amt, a_in_mode, a_in_tag));
         if (a_out_valid && !a_out_ready) begin
            if (a_stall) begin
               chk("a_hold_data", a_out_data, a_hold_data);
               chk("a_hold_tag", a_out_tag, a_hold_tag);
               chk("a_hold_err", a_out_err, a_hold_err);
            end
            a_stall = 1;
            a_hold_data = a_out_data; a_hold_tag = a_out_tag; a_hold_err = a_out_err;
         end else a_stall = 0;
      end else a_stall = 0;
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst) begin
         if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected_beat actual=%0h required=none", b_out_data);
            end else begin
               e = b_q.pop_front();
               chk("b_data", b_out_data, e.data);
               chk("b_tag", b_out_tag, e.tag);
               chk("b_err", b_out_err, e.err);
               b_last_data = b_out_data; b_last_tag = b_out_tag; b_last_err = b_out_err;
            end
         end
         if (b_in_valid && b_in_ready)
            b_q.push_back(model(8, b_in_data, b_in_amt, b_in_mode, b_in_tag));
         if (b_out_valid && !b_out_ready) begin
            if (b_stall) begin
               chk("b_hold_data", b_out_data, b_hold_data);
               chk("b_hold_tag", b_out_tag, b_hold_tag);
               chk("b_hold_err", b_out_err, b_hold_err);
            end
            b_stall = 1;
            b_hold_data = b_out_data; b_hold_tag = b_out_tag; b_hold_err = b_out_err;
         end else b_stall = 0;
      end else b_stall = 0;
   end

   task automatic put(input bit sel, input logic [31:0] d, input int amt,
                      input logic [2:0] m, input logic [3:0] t);
      bit ok = 0;
      if (sel) begin
         b_in_data = d[7:0]; b_in_amt = 3'(amt); b_in_mode = m; b_in_tag = t; b_in_valid = 1'b1;
      end else begin
         a_in_data = d; a_in_amt = 5'(amt); a_in_mode = m; a_in_tag = t; a_in_valid = 1'b1;
      end
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = sel ? b_in_ready : a_in_ready;
         @(posedge clk); #1;
      end
      chk("put_accepted", ok, 1);
   endtask

   task automatic drain(input bit sel);
      int n = 0;
      while ((sel ? b_q.size() : a_q.size()) != 0 && n < 300) begin
         @(negedge clk); #1; n++;
      end
      chk("drain_empty", sel ? b_q.size() : a_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic directed(input bit sel, input logic [31:0] d, input int amt,
                           input logic [2:0] m, input logic [3:0] t, input logic [31:0] exp_d,
                           input logic exp_e, input int exp_lat, input string name);
      int lat = 0;
      put(sel, d, amt, m, t);
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      do begin
         @(negedge clk); lat++;
      end while (!(sel ? b_out_valid : a_out_valid) && lat < 50);
      chk({name, "_latency"}, lat, exp_lat);
      drain(sel);
      chk({name, "_data"}, sel ? {24'd0, b_last_data} : a_last_data, exp_d);
      chk({name, "_err"}, sel ? b_last_err : a_last_err, exp_e);
      chk({name, "_tag"}, sel ? b_last_tag : a_last_tag, t);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      clk = 1'b0; rst = 1'b1; rdy_mode = 1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_mode = '0; a_in_tag = '0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_mode = '0; b_in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {a_out_valid, b_out_valid}, 0);
      chk("rst_out_data", {a_out_data, b_out_data}, 0);
      chk("rst_out_tag_err", {a_out_tag, a_out_err, b_out_tag, b_out_err}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {a_in_ready, b_in_ready}, 2'b11);
      @(posedge clk); #1;

      directed(0, 32'h0000_0001, 31, 3'b000, 4'h1, 32'h8000_0000, 1'b0, 5, "sll31");
      directed(0, 32'h8000_F000, 4, 3'b010, 4'h2, 32'hF800_0F00, 1'b0, 5, "sra4");
      directed(0, 32'h8000_F000, 4, 3'b001, 4'h3, 32'h0800_0F00, 1'b0, 5, "srl4");
      directed(0, 32'h1234_5678, 8, 3'b100, 4'h4, 32'h7812_3456, 1'b0, 5, "ror8");
      directed(0, 32'h1234_5678, 8, 3'b011, 4'h5, 32'h3456_7812, 1'b0, 5, "rol8");
      for (int m = 0; m < 5; m++)
         directed(0, 32'h1234_5678, 0, 3'(m), 4'(m), 32'h1234_5678, 1'b0, 5, "amt0");
      directed(0, 32'hDEAD_BEEF, 4, 3'b111, 4'hA, 32'hDEAD_BEEF, 1'b1, 5, "rsvd");
      directed(1, 32'h01, 7, 3'b000, 4'h6, 32'h80, 1'b0, 1, "w8_sll7");
      directed(1, 32'h81, 1, 3'b100, 4'h7, 32'hC0, 1'b0, 1, "w8_ror1");
      directed(1, 32'hA5, 0, 3'b010, 4'h8, 32'hA5, 1'b0, 1, "w8_amt0");
      directed(1, 32'h3C, 2, 3'b101, 4'h9, 32'h3C, 1'b1, 1, "w8_rsvd");

      // Eight back-to-back beats against a stalled output, then release.
      rdy_mode = 0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 12) rdy_mode = 1;
         if (idx < 8) begin
            a_in_data = $urandom; a_in_amt = 5'($urandom); a_in_mode = 3'($urandom_range(0, 4));
            a_in_tag = 4'(idx); a_in_valid = 1'b1;
         end else a_in_valid = 1'b0;
         @(negedge clk);
         if (c == 11) begin
            chk("bp_accepted", idx, 5);
            chk("bp_in_ready_low", a_in_ready, 0);
         end
         if (a_in_valid && a_in_ready) idx++;
         if (c >= 12) chk("bp_no_gap", a_out_valid, 1);
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      chk("bp_all_accepted", idx, 8);
      drain(0);
      chk("bp_last_tag", a_last_tag, 4'd7);

      rdy_mode = 2;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 150; i++) begin
            put(s[0], $urandom, $urandom_range(0, (s != 0) ? 7 : 31),
                3'($urandom_range(0, 7)), 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
               a_in_valid = 1'b0; b_in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         a_in_valid = 1'b0; b_in_valid = 1'b0;
      end
      rdy_mode = 1;
      drain(0);
      drain(1);

      // Asynchronous reset with three beats in flight.
      rdy_mode = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
         put(0, $urandom, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 4'(i));
      a_in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("pre_rst_valid", a_out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", a_out_valid, 0);
      chk("rst_async_data", a_out_data, 0);
      a_q.delete();
      b_q.delete();
      @(posedge clk); #1;
      rst = 1'b0; rdy_mode = 1;
      @(negedge clk);
      chk("post_rst_in_ready", a_in_ready, 1);
      repeat (10) begin
         @(negedge clk);
         chk("no_stale_beat", a_out_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
